sd_spi_init_sequencer: RTL and testbench

//  Parametrised SPI-mode SD initialisation sequencer; successor to the fixed CMD0/CMD55/ACMD41 controller.

---
 rtl/sd_spi_init_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_sd_spi_init_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_init_sequencer.sv
// SPI-mode SD card initialisation sequencer.
// Runs the power-up dummy clocks and then CMD0, optionally CMD8, and CMD55/ACMD41
// until the card reports ready. Each command is loaded into the SPI shifter, shifted
// out, and its R1 response is polled. The sequencer stops in DONE or ERROR.
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start               pulse; begins init from IDLE/DONE/ERROR
//   rising_edge_sclk    one-cycle strobe per SPI sclk rising edge
//   sd_rsp_msg[7:0]     last byte shifted in by the SPI reader
//   spi_command[47:0]   command frame, valid while spi_load_command=1
//   spi_load_command    load strobe for the shifter
//   spi_shift_command   shift the command out
//   spi_shift_read      shift a response byte in
//   spi_CS              card chip select, active-low
//   busy/done/error     status; done and error held until the next start
//   err_code[2:0]       1 CMD0 fail, 2 CMD8 bad, 3 bad R1, 4 ACMD41 timeout, 5 no response
//   card_hc             card accepted CMD8 (v2 card, HCS requested)
module sd_spi_init_sequencer #(
    parameter int unsigned DUMMY_CLKS   = 80,
    parameter int unsigned NCR_MAX      = 8,
    parameter int unsigned CMD0_RETRIES = 4,
    parameter int unsigned ACMD41_MAX   = 255,
    parameter bit          ENABLE_CMD8  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rising_edge_sclk,
    input  logic [7:0]  sd_rsp_msg,
    output logic [47:0] spi_command,
    output logic        spi_load_command,
    output logic        spi_shift_command,
    output logic        spi_shift_read,
    output logic        spi_CS,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic        card_hc
);

    localparam int unsigned FRAME_W = 48;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned NCR_W   = (NCR_MAX > 2) ? $clog2(NCR_MAX) : 1;
    localparam int unsigned RETRY_W = (CMD0_RETRIES > 2) ? $clog2(CMD0_RETRIES) : 1;
    localparam int unsigned ACMD_W  = (ACMD41_MAX > 2) ? $clog2(ACMD41_MAX) : 1;

    localparam logic [FRAME_W-1:0] FRAME_CMD0      = 48'h40_0000_0000_95;
    localparam logic [FRAME_W-1:0] FRAME_CMD8      = 48'h48_0000_01AA_87;
    localparam logic [FRAME_W-1:0] FRAME_CMD55     = 48'h77_0000_0000_65;
    localparam logic [FRAME_W-1:0] FRAME_ACMD41_HC = 48'h69_4000_0000_77;
    localparam logic [FRAME_W-1:0] FRAME_ACMD41_SC = 48'h69_0000_0000_E5;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_CMD0  = 3'd1;
    localparam logic [2:0] ERR_CMD8  = 3'd2;
    localparam logic [2:0] ERR_R1    = 3'd3;
    localparam logic [2:0] ERR_ACMD  = 3'd4;
    localparam logic [2:0] ERR_NORSP = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_DUMMY, S_LOAD, S_SEND, S_RECV, S_EVAL, S_GAP, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [1:0] {C_CMD0, C_CMD8, C_CMD55, C_ACMD41} cmd_t;

    state_t             state, state_nxt;
    cmd_t               cmd, cmd_nxt;
    logic [CNT_W-1:0]   edge_cnt;
    logic [NCR_W-1:0]   ncr_cnt, ncr_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [ACMD_W-1:0]  acmd_cnt, acmd_nxt;
    logic               in_tail, in_tail_nxt;
    logic [1:0]         tail_cnt, tail_nxt;
    logic               nib_ok, nib_ok_nxt;
    logic               fin_done, fin_done_nxt;
    logic [2:0]         fin_code, fin_code_nxt;
    logic               done_nxt, error_nxt, card_hc_nxt;
    logic [2:0]         err_code_nxt;
    logic               cs_nxt, busy_nxt, load_nxt, shcmd_nxt, shrd_nxt;
    logic [FRAME_W-1:0] frame_nxt;
    logic               hit_dummy, hit_frame, hit_byte;

    function automatic logic [FRAME_W-1:0] frame_of(input cmd_t c, input logic hc);
        logic [FRAME_W-1:0] f;
        case (c)
            C_CMD0:  f = FRAME_CMD0;
            C_CMD8:  f = FRAME_CMD8;
            C_CMD55: f = FRAME_CMD55;
            default: f = hc ? FRAME_ACMD41_HC : FRAME_ACMD41_SC;
        endcase
        return f;
    endfunction

    // Strobe that completes the current phase's sclk edge budget
    assign hit_dummy = rising_edge_sclk && (edge_cnt == CNT_W'(DUMMY_CLKS - 1));
    assign hit_frame = rising_edge_sclk && (edge_cnt == CNT_W'(FRAME_W - 1));
    assign hit_byte  = rising_edge_sclk && (edge_cnt == CNT_W'(7));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and protocol decisions
    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        ncr_nxt      = ncr_cnt;
        retry_nxt    = retry_cnt;
        acmd_nxt     = acmd_cnt;
        in_tail_nxt  = in_tail;
        tail_nxt     = tail_cnt;
        nib_ok_nxt   = nib_ok;
        fin_done_nxt = fin_done;
        fin_code_nxt = fin_code;
        done_nxt     = done;
        error_nxt    = error;
        err_code_nxt = err_code;
        card_hc_nxt  = card_hc;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt    = S_DUMMY;
                    cmd_nxt      = C_CMD0;
                    retry_nxt    = '0;
                    acmd_nxt     = '0;
                    in_tail_nxt  = 1'b0;
                    tail_nxt     = '0;
                    nib_ok_nxt   = 1'b0;
                    fin_done_nxt = 1'b0;
                    fin_code_nxt = ERR_NONE;
                    done_nxt     = 1'b0;
                    error_nxt    = 1'b0;
                    err_code_nxt = ERR_NONE;
                    card_hc_nxt  = 1'b0;
                end
            end
            S_DUMMY: if (hit_dummy) state_nxt = S_LOAD;
            S_LOAD: begin
                ncr_nxt   = '0;
                state_nxt = S_SEND;
            end
            S_SEND: if (hit_frame) state_nxt = S_RECV;
            S_RECV: if (hit_byte) state_nxt = S_EVAL;
            S_EVAL: begin
                state_nxt = S_GAP;
                if (in_tail) begin
                    // CMD8 R7 trailer: bytes 1..4 after R1, no NCR polling
                    tail_nxt = tail_cnt + 2'd1;
                    if (tail_cnt == 2'd2) nib_ok_nxt = (sd_rsp_msg[3:0] == 4'h1);
                    if (tail_cnt == 2'd3) begin
                        in_tail_nxt = 1'b0;
                        if (nib_ok && sd_rsp_msg == 8'hAA) begin
                            card_hc_nxt = 1'b1;
                            cmd_nxt     = C_CMD55;
                        end else begin
                            fin_code_nxt = ERR_CMD8;
                        end
                    end else begin
                        state_nxt = S_RECV;
                    end
                end else if (sd_rsp_msg[7]) begin
                    // Card still idle on the line: poll another byte
                    if (ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
                        fin_code_nxt = ERR_NORSP;
                    end else begin
                        ncr_nxt   = ncr_cnt + NCR_W'(1);
                        state_nxt = S_RECV;
                    end
                end else begin
                    case (cmd)
                        C_CMD0: begin
                            if (sd_rsp_msg == 8'h01)
                                cmd_nxt = ENABLE_CMD8 ? C_CMD8 : C_CMD55;
                            else if (retry_cnt == RETRY_W'(CMD0_RETRIES - 1))
                                fin_code_nxt = ERR_CMD0;
                            else
                                retry_nxt = retry_cnt + RETRY_W'(1);
                        end
                        C_CMD8: begin
                            if (sd_rsp_msg == 8'h05) begin
                                card_hc_nxt = 1'b0;
                                cmd_nxt     = C_CMD55;
                            end else if (sd_rsp_msg == 8'h01) begin
                                in_tail_nxt = 1'b1;
                                tail_nxt    = '0;
                                state_nxt   = S_RECV;
                            end else begin
                                fin_code_nxt = ERR_CMD8;
                            end
                        end
                        C_CMD55: begin
                            if (sd_rsp_msg == 8'h00 || sd_rsp_msg == 8'h01)
                                cmd_nxt = C_ACMD41;
                            else
                                fin_code_nxt = ERR_R1;
                        end
                        default: begin
                            if (sd_rsp_msg == 8'h00) begin
                                fin_done_nxt = 1'b1;
                            end else if (sd_rsp_msg == 8'h01) begin
                                if (acmd_cnt == ACMD_W'(ACMD41_MAX - 1)) begin
                                    fin_code_nxt = ERR_ACMD;
                                end else begin
                                    acmd_nxt = acmd_cnt + ACMD_W'(1);
                                    cmd_nxt  = C_CMD55;
                                end
                            end else begin
                                fin_code_nxt = ERR_R1;
                            end
                        end
                    endcase
                end
            end
            S_GAP: begin
                if (hit_byte) begin
                    if (fin_done) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else if (fin_code != ERR_NONE) begin
                        state_nxt    = S_ERROR;
                        error_nxt    = 1'b1;
                        err_code_nxt = fin_code;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so registered outputs align with it
    always_comb begin
        cs_nxt    = 1'b1;
        busy_nxt  = 1'b1;
        load_nxt  = 1'b0;
        shcmd_nxt = 1'b0;
        shrd_nxt  = 1'b0;
        frame_nxt = '0;
        case (state_nxt)
            S_IDLE, S_DONE, S_ERROR: busy_nxt = 1'b0;
            S_LOAD: begin
                cs_nxt    = 1'b0;
                load_nxt  = 1'b1;
                frame_nxt = frame_of(cmd_nxt, card_hc_nxt);
            end
            S_SEND: begin
                cs_nxt    = 1'b0;
                shcmd_nxt = 1'b1;
            end
            S_RECV: begin
                cs_nxt   = 1'b0;
                shrd_nxt = 1'b1;
            end
            S_EVAL:  cs_nxt = 1'b0;
            default: ;
        endcase
    end

    // Datapath registers; the edge counter restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd      <= C_CMD0;
            edge_cnt <= '0;
            ncr_cnt  <= '0;
            retry_cnt <= '0;
            acmd_cnt <= '0;
            in_tail  <= 1'b0;
            tail_cnt <= '0;
            nib_ok   <= 1'b0;
            fin_done <= 1'b0;
            fin_code <= ERR_NONE;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            card_hc  <= 1'b0;
        end else begin
            cmd      <= cmd_nxt;
            if (state_nxt != state)   edge_cnt <= '0;
            else if (rising_edge_sclk) edge_cnt <= edge_cnt + CNT_W'(1);
            ncr_cnt  <= ncr_nxt;
            retry_cnt <= retry_nxt;
            acmd_cnt <= acmd_nxt;
            in_tail  <= in_tail_nxt;
            tail_cnt <= tail_nxt;
            nib_ok   <= nib_ok_nxt;
            fin_done <= fin_done_nxt;
            fin_code <= fin_code_nxt;
            done     <= done_nxt;
            error    <= error_nxt;
            err_code <= err_code_nxt;
            card_hc  <= card_hc_nxt;
        end
    end

    // Registered SPI controls and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_CS            <= 1'b1;
            busy              <= 1'b0;
            spi_load_command  <= 1'b0;
            spi_shift_command <= 1'b0;
            spi_shift_read    <= 1'b0;
            spi_command       <= '0;
        end else begin
            spi_CS            <= cs_nxt;
            busy              <= busy_nxt;
            spi_load_command  <= load_nxt;
            spi_shift_command <= shcmd_nxt;
            spi_shift_read    <= shrd_nxt;
            spi_command       <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_sd_spi_init_sequencer.sv
// Testbench for sd_spi_init_sequencer: a scripted SD card answers each command
// through a byte-level SPI reader model. Expected frames, responses and outcome
// come from a command-level protocol model.
module tb_sd_spi_init_sequencer;

    localparam int unsigned DUMMY_CLKS   = 80;
    localparam int unsigned NCR_MAX      = 8;
    localparam int unsigned CMD0_RETRIES = 4;
    localparam int unsigned ACMD41_MAX   = 4;
    localparam int          BUDGET       = 20000;

    localparam logic [47:0] F_CMD0   = 48'h40_0000_0000_95;
    localparam logic [47:0] F_CMD8   = 48'h48_0000_01AA_87;
    localparam logic [47:0] F_CMD55  = 48'h77_0000_0000_65;
    localparam logic [47:0] F_A41_HC = 48'h69_4000_0000_77;
    localparam logic [47:0] F_A41_SC = 48'h69_0000_0000_E5;

    logic        clk, rst, start, rising_edge_sclk;
    logic [7:0]  sd_rsp_msg;
    logic [47:0] spi_command;
    logic        spi_load_command, spi_shift_command, spi_shift_read, spi_CS;
    logic        busy, done, error, card_hc;
    logic [2:0]  err_code;

    int n_checks, n_fail;

    // Reference model state
    logic [47:0] exp_cmd_q[$];
    logic [7:0]  rsp_q[$];
    bit          exp_done, exp_hc;
    int          exp_code;
    bit          rnd_delay, rand_bad;
    int          first_delay, reply_idx;

    sd_spi_init_sequencer #(
        .DUMMY_CLKS  (DUMMY_CLKS),
        .NCR_MAX     (NCR_MAX),
        .CMD0_RETRIES(CMD0_RETRIES),
        .ACMD41_MAX  (ACMD41_MAX),
        .ENABLE_CMD8 (1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .rising_edge_sclk (rising_edge_sclk),
        .sd_rsp_msg       (sd_rsp_msg),
        .spi_command      (spi_command),
        .spi_load_command (spi_load_command),
        .spi_shift_command(spi_shift_command),
        .spi_shift_read   (spi_shift_read),
        .spi_CS           (spi_CS),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .err_code         (err_code),
        .card_hc          (card_hc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Card answers one command: optional NCR idle bytes, then R1 (or never)
    task automatic reply(input logic [7:0] r1, output bit ok);
        int d;
        if (reply_idx == 0 && first_delay >= 0) d = first_delay;
        else if (!rnd_delay)                     d = 0;
        else if ($urandom_range(0, 24) == 0)     d = int'(NCR_MAX);
        else                                     d = int'($urandom_range(0, 3));
        reply_idx++;
        for (int i = 0; i < d; i++) rsp_q.push_back(8'hFF);
        ok = (d < int'(NCR_MAX));
        if (ok) rsp_q.push_back(r1);
        else    exp_code = 5;
    endtask

    // Protocol walk: kind 0 v2 card, 1 v1 card, 2 bad CMD8 trailer, 3 bad CMD8 R1
    task automatic build(input int cmd0_fail, input int kind, input int acmd_busy);
        bit ok;
        logic [7:0] r;
        exp_cmd_q.delete();
        rsp_q.delete();
        exp_done = 0; exp_hc = 0; exp_code = 0; reply_idx = 0;
        for (int a = 0; ; a++) begin
            exp_cmd_q.push_back(F_CMD0);
            reply((a < cmd0_fail) ? 8'h00 : 8'h01, ok);
            if (!ok) return;
            if (a >= cmd0_fail) break;
            if (a + 1 == int'(CMD0_RETRIES)) begin exp_code = 1; return; end
        end
        exp_cmd_q.push_back(F_CMD8);
        case (kind)
            0: begin
                reply(8'h01, ok);
                if (!ok) return;
                rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
                rsp_q.push_back(8'h01); rsp_q.push_back(8'hAA);
                exp_hc = 1;
            end
            1: begin
                reply(8'h05, ok);
                if (!ok) return;
            end
            2: begin
                reply(8'h01, ok);
                if (!ok) return;
                rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
                if ($urandom_range(0, 1) == 1) begin
                    rsp_q.push_back(8'h01); rsp_q.push_back(8'h55);
                end else begin
                    rsp_q.push_back(8'h02); rsp_q.push_back(8'hAA);
                end
                exp_code = 2;
                return;
            end
            default: begin
                reply(8'h09, ok);
                if (ok) exp_code = 2;
                return;
            end
        endcase
        for (int att = 0; ; att++) begin
            exp_cmd_q.push_back(F_CMD55);
            if (rand_bad && $urandom_range(0, 15) == 0) begin
                reply(8'h04, ok);
                if (ok) exp_code = 3;
                return;
            end
            r = (rand_bad && $urandom_range(0, 1) == 1) ? 8'h00 : 8'h01;
            reply(r, ok);
            if (!ok) return;
            exp_cmd_q.push_back(exp_hc ? F_A41_HC : F_A41_SC);
            r = (att < acmd_busy) ? 8'h01 : 8'h00;
            if (rand_bad && $urandom_range(0, 19) == 0) r = 8'h05;
            reply(r, ok);
            if (!ok) return;
            if (r == 8'h00) begin exp_done = 1; return; end
            if (r != 8'h01) begin exp_code = 3; return; end
            if (att + 1 == int'(ACMD41_MAX)) begin exp_code = 4; return; end
        end
    endtask

    // Start a sequence and act as sclk source and SPI reader until it settles
    task automatic run_case(input string tag);
        bit          first, fin;
        int          gap, rd_bits, spur;
        logic [47:0] exp_f;
        first = 1; fin = 0; gap = 0; rd_bits = 0;
        spur = int'($urandom_range(20, 400));
        @(negedge clk);
        rising_edge_sclk = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        check({tag, " busy_after_start"}, 48'(busy), 48'(1));
        check({tag, " done_cleared"}, 48'(done), 48'(0));
        check({tag, " error_cleared"}, 48'({error, err_code}), 48'(0));
        check({tag, " hc_cleared"}, 48'(card_hc), 48'(0));
        check({tag, " cs_dummy"}, 48'(spi_CS), 48'(1));
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            start = 0;
            if (!busy) begin fin = 1; break; end
            rising_edge_sclk = ($urandom_range(0, 2) != 0);
            if (cyc == spur) start = 1;
            check({tag, " strobe_onehot"},
                  48'($onehot0({spi_load_command, spi_shift_command, spi_shift_read})), 48'(1));
            if (spi_load_command) begin
                check({tag, first ? " dummy_edges" : " gap_edges"}, 48'(gap),
                      first ? 48'(DUMMY_CLKS) : 48'(8));
                exp_f = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : 48'h0;
                check({tag, " frame"}, spi_command, exp_f);
                gap = 0;
                first = 0;
            end
            if (rising_edge_sclk && spi_CS && busy) gap++;
            if (rising_edge_sclk && spi_shift_read) begin
                rd_bits++;
                if (rd_bits == 8) begin
                    rd_bits = 0;
                    sd_rsp_msg = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hFF;
                end
            end
            @(negedge clk);
        end
        rising_edge_sclk = 0;
        start = 0;
        check({tag, " finished"}, 48'(fin), 48'(1));
        check({tag, " done"}, 48'(done), 48'(exp_done));
        check({tag, " error"}, 48'(error), 48'(exp_code != 0));
        check({tag, " err_code"}, 48'(err_code), 48'(exp_code));
        check({tag, " card_hc"}, 48'(card_hc), 48'(exp_hc));
        check({tag, " cs_idle"}, 48'(spi_CS), 48'(1));
        check({tag, " frames_left"}, 48'(exp_cmd_q.size()), 48'(0));
        check({tag, " bytes_left"}, 48'(rsp_q.size()), 48'(0));
    endtask

    initial begin
        bit saw;
        int k;
        n_checks = 0; n_fail = 0;
        clk = 0; rst = 1; start = 0; rising_edge_sclk = 0; sd_rsp_msg = 8'h00;
        rnd_delay = 0; rand_bad = 0; first_delay = -1;
        repeat (3) @(negedge clk);
        check("rst cs", 48'(spi_CS), 48'(1));
        check("rst status", 48'({busy, done, error, err_code, card_hc}), 48'(0));
        check("rst strobes", 48'({spi_load_command, spi_shift_command, spi_shift_read}), 48'(0));
        check("rst frame", spi_command, 48'h0);
        rst = 0;
        @(negedge clk);
        check("idle busy", 48'(busy), 48'(0));

        build(0, 0, 3); run_case("v2");
        build(0, 1, 0); run_case("v1");
        first_delay = 3; build(0, 0, 0); run_case("ncr3");
        first_delay = 8; build(0, 0, 0); run_case("ncr8");
        first_delay = -1;
        build(0, 0, 4); run_case("acmd_timeout");
        build(4, 1, 0); run_case("cmd0_fail");
        build(1, 3, 0); run_case("cmd8_bad");

        // Reset while a command is being shifted out
        build(0, 0, 0);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        saw = 0;
        for (int c = 0; c < BUDGET; c++) begin
            if (spi_shift_command) begin saw = 1; break; end
            rising_edge_sclk = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        rising_edge_sclk = 0;
        check("send reached", 48'(saw), 48'(1));
        check("send cs low", 48'(spi_CS), 48'(0));
        #2 rst = 1;
        #1;
        check("async rst cs", 48'(spi_CS), 48'(1));
        check("async rst busy", 48'(busy), 48'(0));
        check("async rst shift", 48'(spi_shift_command), 48'(0));
        @(negedge clk);
        rst = 0;
        build(0, 0, 3); run_case("restart");

        rnd_delay = 1; rand_bad = 1;
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 5));
            build(int'($urandom_range(0, 4)),
                  (k < 2) ? 0 : (k < 4) ? 1 : (k == 4) ? 2 : 3,
                  int'($urandom_range(0, 5)));
            run_case($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
